// File: rtl/seg7_scan_if.sv
// Bus between the IO decoder and the 7-segment scan driver: value load
// strobe and blanking on the way in, anode/cathode pins and commit pulse out.
interface seg7_scan_if;
  logic        load;
  logic [31:0] data;
  logic        blank;
  logic [7:0]  an;
  logic [6:0]  a2g;
  logic        commit;

  modport master (output load, data, blank, input an, a2g, commit);
  modport slave  (input load, data, blank, output an, a2g, commit);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 8-digit hex display driver.
// A loaded 32-bit value waits in a pending register and becomes the displayed
// value only at the digit 7 -> 0 frame boundary, so a frame never tears.
// Build option: define LZ_BLANK_EN for leading-zero blanking (digit 0 always lit).
module seg7_scan #(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input logic   clk,
  input logic   reset,
  seg7_scan_if.slave bus
);

  localparam int unsigned CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   disp;
  logic [31:0]   pend;
  logic          pend_v;
  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic [7:0]    lit;
  logic [7:0]    an_q;
  logic [6:0]    a2g_q;
  logic          commit_q;

  assign tick = (cnt == CW'(DIGIT_CYCLES - 1));
  assign wrap = tick && (idx == 3'd7);
  assign nib  = disp[{idx, 2'b00} +: 4];

  assign bus.an     = an_q;
  assign bus.a2g    = a2g_q;
  assign bus.commit = commit_q;

  // Hex nibble to active-low {a,b,c,d,e,f,g} cathode pattern
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end

`ifdef LZ_BLANK_EN
  logic lz_seen;

  // Digit k is lit if it or any higher nibble is nonzero; digit 0 always lit
  always_comb begin
    lit     = 8'h01;
    lz_seen = 1'b0;
    for (int unsigned k = 7; k >= 1; k--) begin
      if (disp[4*k +: 4] != 4'h0) lz_seen = 1'b1;
      lit[k] = lz_seen;
    end
  end
`else
  // Every digit is lit
  always_comb begin
    lit = '1;
  end
`endif

  // Prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Pending capture and frame-boundary commit; a load in the wrap cycle goes straight to disp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp     <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (wrap) begin
        if (bus.load) begin
          disp     <= bus.data;
          pend_v   <= 1'b0;
          commit_q <= 1'b1;
        end else if (pend_v) begin
          disp     <= pend;
          pend_v   <= 1'b0;
          commit_q <= 1'b1;
        end
      end else if (bus.load) begin
        pend   <= bus.data;
        pend_v <= 1'b1;
      end
    end
  end

  // Registered pin drive from the current index and displayed value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      a2g_q <= '1;
    end else begin
      an_q  <= bus.blank ? 8'hFF : ~((8'h01 << idx) & lit);
      a2g_q <= seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with DIGIT_CYCLES=4: a cycle model pushes
// expected pin values into a queue at each rising edge, and they are popped and
// compared on the falling edge; table vectors and hand sequences add targeted checks.
module tb_seg7_scan;

  localparam int unsigned DC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seg7_scan_if bus ();

  seg7_scan #(.DIGIT_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int commits = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] a2g;
    logic       commit;
  } exp_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } vec_t;

  exp_t sbq[$];

  int unsigned m_cnt;
  logic [2:0]  m_idx;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  logic        m_pv;
  logic        m_wrap;

  assign m_wrap = (m_cnt == DC - 1) && (m_idx == 3'd7);

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [7:0] lit_of(input logic [31:0] d);
    logic [7:0] r;
`ifdef LZ_BLANK_EN
    int hi;
    hi = 0;
    for (int k = 0; k < 8; k++) if (d[4*k +: 4] != 4'h0) hi = k;
    r = '0;
    for (int k = 0; k <= hi; k++) r[k] = 1'b1;
`else
    r = 8'hFF;
`endif
    return r;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [7:0] onehot;
    onehot   = 8'h01 << m_idx;
    e.an     = bus.blank ? 8'hFF : (8'hFF ^ (onehot & lit_of(m_disp)));
    e.a2g    = seg_of(m_disp[m_idx*4 +: 4]);
    e.commit = m_wrap && (bus.load || m_pv);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: predict next pin values, then advance its own state
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_idx  <= '0;
      m_disp <= '0;
      m_pend <= '0;
      m_pv   <= 1'b0;
      sbq.delete();
    end else begin
      sbq.push_back(model_out());
      if (m_wrap && bus.load) begin
        m_disp <= bus.data;
        m_pv   <= 1'b0;
      end else if (m_wrap && m_pv) begin
        m_disp <= m_pend;
        m_pv   <= 1'b0;
      end else if (bus.load) begin
        m_pend <= bus.data;
        m_pv   <= 1'b1;
      end
      m_cnt <= (m_cnt == DC - 1) ? 0 : m_cnt + 1;
      if (m_cnt == DC - 1) m_idx <= m_idx + 3'd1;
    end
  end

  // Scoreboard: compare DUT pins against the model on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      check("reset_pins", {16'h0, bus.an, bus.a2g, bus.commit}, {16'h0, 8'hFF, 7'h7F, 1'b0});
    end else if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("scoreboard", {16'h0, bus.an, bus.a2g, bus.commit}, {16'h0, e});
      if (bus.commit) commits++;
    end
  end

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic wait_idx(input logic [2:0] i);
    int n;
    n = 0;
    while (m_idx != i && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (m_idx != i) timeout("wait_idx");
  endtask

  task automatic wait_an(input logic [7:0] v);
    int n;
    n = 0;
    while (bus.an !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.an !== v) timeout("wait_an");
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.commit !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (bus.commit !== 1'b1) timeout("wait_commit");
  endtask

  task automatic load_word(input logic [31:0] v);
    bus.load = 1'b1;
    bus.data = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[16];
    int c0;
    logic [7:0] want_an;
    int n;

    vt[0]  = '{4'h0, 7'b0000001}; vt[1]  = '{4'h1, 7'b1001111};
    vt[2]  = '{4'h2, 7'b0010010}; vt[3]  = '{4'h3, 7'b0000110};
    vt[4]  = '{4'h4, 7'b1001100}; vt[5]  = '{4'h5, 7'b0100100};
    vt[6]  = '{4'h6, 7'b0100000}; vt[7]  = '{4'h7, 7'b0001111};
    vt[8]  = '{4'h8, 7'b0000000}; vt[9]  = '{4'h9, 7'b0000100};
    vt[10] = '{4'hA, 7'b0001000}; vt[11] = '{4'hB, 7'b1100000};
    vt[12] = '{4'hC, 7'b0110001}; vt[13] = '{4'hD, 7'b1000010};
    vt[14] = '{4'hE, 7'b0110000}; vt[15] = '{4'hF, 7'b0111000};

    bus.load  = 1'b0;
    bus.data  = '0;
    bus.blank = 1'b0;

    // Reset state and first cycle after release
    repeat (3) @(negedge clk);
    check("rst_an", {24'h0, bus.an}, 32'hFF);
    check("rst_a2g", {25'h0, bus.a2g}, 32'h7F);
    reset = 1'b0;
    @(negedge clk);
    check("first_an", {24'h0, bus.an}, 32'hFE);
    check("first_a2g", {25'h0, bus.a2g}, 32'h01);

`ifndef LZ_BLANK_EN
    // Anode walks FD..7F every DIGIT_CYCLES and wraps to FE
    for (int k = 1; k <= 8; k++) begin
      repeat (DC) @(negedge clk);
      want_an = ~(8'h01 << (k % 8));
      check("an_step", {24'h0, bus.an}, {24'h0, want_an});
    end
`endif

    // Mid-frame load is held until the frame boundary
    wait_idx(3'd3);
    c0 = commits;
    load_word(32'h12345678);
    wait_commit();
    @(negedge clk);
    check("ld_idx0_an", {24'h0, bus.an}, 32'hFE);
    check("ld_idx0_a2g", {25'h0, bus.a2g}, 32'h00);
    wait_an(8'h7F);
    check("ld_idx7_a2g", {25'h0, bus.a2g}, {25'h0, 7'b1001111});
    repeat (8) @(negedge clk);
    check("ld_commit_once", commits - c0, 1);

    // Two loads before the boundary: last wins, one commit
    wait_idx(3'd1);
    c0 = commits;
    bus.load = 1'b1;
    bus.data = 32'h11111111;
    @(negedge clk);
    bus.data = 32'hDEADBEEF;
    @(negedge clk);
    bus.load = 1'b0;
    wait_commit();
    @(negedge clk);
    check("dbl_idx0_a2g", {25'h0, bus.a2g}, {25'h0, 7'b0111000});
    wait_an(8'h7F);
    check("dbl_idx7_a2g", {25'h0, bus.a2g}, {25'h0, 7'b1000010});
    repeat (8) @(negedge clk);
    check("dbl_commit_once", commits - c0, 1);

    // Load in the wrap cycle bypasses pend and commits in the same frame
    n = 0;
    while (!m_wrap && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!m_wrap) timeout("wait_wrap");
    c0 = commits;
    load_word(32'h0000000A);
    check("wrap_commit", {31'h0, bus.commit}, 32'h1);
    @(negedge clk);
    check("wrap_idx0_an", {24'h0, bus.an}, 32'hFE);
    check("wrap_idx0_a2g", {25'h0, bus.a2g}, {25'h0, 7'b0001000});
    repeat (40) @(negedge clk);
    check("wrap_no_recommit", commits - c0, 1);

    // Encoding table: fill every digit with one nibble, read it at digit 0
    for (int i = 0; i < 16; i++) begin
      wait_idx(3'd2);
      load_word({8{vt[i].nib}});
      wait_commit();
      @(negedge clk);
      check($sformatf("enc_%0h", vt[i].nib), {25'h0, bus.a2g}, {25'h0, vt[i].seg});
    end

    // Blanking holds all anodes off while scanning continues
    @(negedge clk);
    bus.blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("blank_an", {24'h0, bus.an}, 32'hFF);
    end
    bus.blank = 1'b0;
    repeat (8) @(negedge clk);

`ifdef LZ_BLANK_EN
    // Leading-zero blanking on 0x00000A05
    wait_idx(3'd2);
    load_word(32'h00000A05);
    wait_commit();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("lz_upper_off", {27'h0, bus.an[7:3]}, 32'h1F);
    end
    wait_an(8'hFE);
    check("lz_d0", {25'h0, bus.a2g}, {25'h0, 7'b0100100});
    wait_an(8'hFD);
    check("lz_d1", {25'h0, bus.a2g}, {25'h0, 7'b0000001});
    wait_an(8'hFB);
    check("lz_d2", {25'h0, bus.a2g}, {25'h0, 7'b0001000});
`endif

    // Asynchronous reset mid-frame discards pending data
    wait_idx(3'd5);
    load_word(32'hCAFEF00D);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_an", {24'h0, bus.an}, 32'hFF);
    check("arst_a2g", {25'h0, bus.a2g}, 32'h7F);
    check("arst_commit", {31'h0, bus.commit}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c0 = commits;
    @(negedge clk);
    check("arst_rel_an", {24'h0, bus.an}, 32'hFE);
    check("arst_rel_a2g", {25'h0, bus.a2g}, 32'h01);
    repeat (40) @(negedge clk);
    check("arst_no_commit", commits - c0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
